lcd_rx: RTL
===========

LCD_RX -- requirements
Module: lcd_rx

Interface
REQ-001 Parameter BUSY_CYCLES, default 20, busy length in clk cycles after a normal accepted write (used only with LCD_RX_BUSY_EN).
REQ-002 Parameter BUSY_LONG_CYCLES, default 800, busy length in clk cycles after a return-home command (used only with LCD_RX_BUSY_EN).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 lcd_e  input  1  bus enable strobe from the calculator LCD driver.
REQ-006 lcd_rs  input  1  register select: 0 = instruction, 1 = data.
REQ-007 lcd_rw  input  1  0 = write, 1 = read.
REQ-008 lcd_data  input  8  bus data.
REQ-009 rd_addr  input  5  character buffer read address: 0-15 line 1, 16-31 line 2.
REQ-010 rd_char  output  8  buffer[rd_addr], registered, 1-cycle latency.
REQ-011 cursor  output  5  current write position.
REQ-012 wr_strobe  output  1  one-cycle pulse when a character is stored.
REQ-013 busy  output  1  high in CLEAR or BUSY state.
REQ-014 err  output  1  sticky protocol error flag.

Function
REQ-015 lcd_rs, lcd_rw and lcd_data SHALL be registered every cycle lcd_e=1; a transaction SHALL commit on the first edge where lcd_e=0 and the previously sampled lcd_e=1, using the registered values.
REQ-016 States SHALL be IDLE, CLEAR and BUSY; transactions commit only in IDLE, and a transaction in CLEAR or BUSY SHALL be dropped and set err.
REQ-017 Read transactions (rw=1) SHALL be ignored without setting err.
REQ-018 Instruction 0x01 SHALL enter CLEAR: write 0x20 to entries 0..31, one per cycle (32 cycles), set cursor=0 and increment mode, then return to IDLE.
REQ-019 Instructions 0x02/0x03 SHALL set cursor=0.
REQ-020 Instructions 0x04-0x07 SHALL set increment mode when lcd_data[1]=1 and decrement mode when lcd_data[1]=0.
REQ-021 Instruction 0x80|a SHALL set cursor=a for a in 0x00-0x0F and cursor=16+(a-0x40) for a in 0x40-0x4F; other values of a SHALL leave cursor unchanged and set err.
REQ-022 All other instructions (function set, display control, shift) SHALL be accepted and ignored.
REQ-023 A data write (rs=1, rw=0) SHALL store lcd_data at buffer[cursor], pulse wr_strobe in the same cycle, and step cursor modulo 32 (31->0 on increment, 0->31 on decrement).
REQ-024 When rd_addr equals the address being written, rd_char SHALL return the old value (read-before-write).
REQ-025 Once set, err SHALL stay high until rst.

Reset
REQ-026 rst SHALL override all other inputs.
REQ-027 rst SHALL set cursor=0, increment mode, err=0, wr_strobe=0 and rd_char=0x20, and SHALL enter CLEAR at index 0, so busy=1 for the 32 cycles after rst falls.
REQ-028 rst asserted mid-CLEAR or mid-BUSY SHALL restart the CLEAR sequence from index 0.

Configuration
REQ-029 With macro LCD_RX_BUSY_EN defined, an accepted write SHALL enter BUSY: return-home for BUSY_LONG_CYCLES cycles, all other writes for BUSY_CYCLES cycles; clear uses CLEAR only.
REQ-030 Without LCD_RX_BUSY_EN, the BUSY state SHALL not exist, and busy reflects CLEAR only.

Structure
REQ-031 Package lcd_rx_pkg SHALL hold the state encoding, opcode constants (CLEAR, HOME, ENTRY, SET_DDRAM), the SPACE constant 0x20 and the line base addresses 0x00/0x40.
REQ-032 Sub-module lcd_rx_ram SHALL implement the 32x8 buffer with synchronous write and registered read.

Verification
REQ-033 Pulse rst, wait 32 cycles -> busy=1 for exactly 32 cycles after rst falls, then 0; rd_char=0x20 for all 32 addresses.
REQ-034 Data writes 0x41 then 0x42 -> buffer[0]=0x41, buffer[1]=0x42, cursor=2, two wr_strobe pulses.
REQ-035 Instruction 0xC0, then data 0x31 -> buffer[16]=0x31, cursor=17; instruction 0x90 -> err=1, cursor unchanged.
REQ-036 Instruction 0x04 at cursor=0, then data 0x58 -> buffer[0]=0x58, cursor=31.
REQ-037 Filled buffer, instruction 0x01, then a data write 3 cycles later -> write dropped, err=1; after 32 cycles all entries=0x20 and cursor=0.
REQ-038 With LCD_RX_BUSY_EN and BUSY_CYCLES=20, two data writes 5 cycles apart -> second write dropped, err=1; without the macro, both writes are stored and err=0.

Source files
------------

// File: rtl/lcd_rx_pkg.sv
// Shared definitions for the lcd_rx character-LCD bus receiver.
// Optional feature macro: LCD_RX_BUSY_EN (adds the post-write BUSY state).
package lcd_rx_pkg;

    // Controller state. BUSY only exists when the busy emulation is built in.
`ifdef LCD_RX_BUSY_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;
`endif

    // HD44780-style instruction opcodes that the receiver interprets.
    localparam logic [7:0] OP_CLEAR     = 8'h01;
    localparam logic [7:0] OP_HOME      = 8'h02;
    localparam logic [7:0] OP_ENTRY     = 8'h04;
    localparam logic [7:0] OP_SET_DDRAM = 8'h80;

    // Fill character written by a clear.
    localparam logic [7:0] SPACE = 8'h20;

    // DDRAM base addresses of the two visible 16-character lines.
    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;

    // Character buffer geometry.
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;

    // Result of translating a DDRAM address into a buffer index.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] idx;
    } ddram_map_t;

    // Map a 7-bit DDRAM address onto the 32-entry buffer; only the first
    // 16 columns of each line are backed by storage.
    function automatic ddram_map_t map_ddram(input logic [6:0] addr);
        ddram_map_t m;
        m.valid = 1'b0;
        m.idx   = '0;
        if (addr[6:4] == LINE1_BASE[6:4]) begin
            m.valid = 1'b1;
            m.idx   = {1'b0, addr[3:0]};
        end else if (addr[6:4] == LINE2_BASE[6:4]) begin
            m.valid = 1'b1;
            m.idx   = {1'b1, addr[3:0]};
        end
        return m;
    endfunction

endpackage

// File: rtl/lcd_rx_ram.sv
// 32x8 character buffer: synchronous write, registered read-before-write port.
module lcd_rx_ram
    import lcd_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_d;
    logic [7:0] rdata_q;

    // Read mux; the register below samples the pre-write contents.
    always_comb begin
        rdata_d = mem_q[raddr];
    end

    // Storage array: one write per cycle, no reset (cleared by the controller).
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read data register, reset to a blank character.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= SPACE;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lcd_rx.sv
// Receiver for a calculator's character-LCD bus: decodes instructions and
// data writes into a 32-character buffer with cursor tracking.
// Optional feature macro: LCD_RX_BUSY_EN (hold off writes for a fixed time
// after each accepted write, longer after return-home).
module lcd_rx
    import lcd_rx_pkg::*;
#(
    parameter int BUSY_CYCLES      = 20,
    parameter int BUSY_LONG_CYCLES = 800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lcd_e,
    input  logic              lcd_rs,
    input  logic              lcd_rw,
    input  logic [7:0]        lcd_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_char,
    output logic [ADDR_W-1:0] cursor,
    output logic              wr_strobe,
    output logic              busy,
    output logic              err
);

    if (BUSY_CYCLES < 1 || BUSY_LONG_CYCLES < 1) begin : g_bad_busy_param
        $error("lcd_rx: busy lengths must be at least one cycle");
    end

`ifdef LCD_RX_BUSY_EN
    localparam int BUSY_MAX = (BUSY_LONG_CYCLES > BUSY_CYCLES) ? BUSY_LONG_CYCLES : BUSY_CYCLES;
    localparam int CNT_W    = $clog2(BUSY_MAX + 1);
    logic [CNT_W-1:0] busy_cnt_d, busy_cnt_q;
`endif

    state_t            state_d, state_q;
    logic [ADDR_W-1:0] clr_idx_d, clr_idx_q;
    logic [ADDR_W-1:0] cursor_d, cursor_q;
    logic              incr_d, incr_q;
    logic              err_d, err_q;
    logic              wr_strobe_d, wr_strobe_q;
    logic              e_d, e_q;
    logic              rs_d, rs_q;
    logic              rw_d, rw_q;
    logic [7:0]        data_d, data_q;

    logic              commit;
    logic              wr_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;
    ddram_map_t        ddram;

    // Bus capture, transaction decode and the IDLE/CLEAR/BUSY controller.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        cursor_d    = cursor_q;
        incr_d      = incr_q;
        err_d       = err_q;
        wr_strobe_d = 1'b0;
        e_d         = lcd_e;
        rs_d        = rs_q;
        rw_d        = rw_q;
        data_d      = data_q;
        ram_we      = 1'b0;
        ram_waddr   = cursor_q;
        ram_wdata   = data_q;
`ifdef LCD_RX_BUSY_EN
        busy_cnt_d  = busy_cnt_q;
`endif

        if (lcd_e) begin
            rs_d   = lcd_rs;
            rw_d   = lcd_rw;
            data_d = lcd_data;
        end

        // Falling edge of the strobe as seen by the sampled copy.
        commit = e_q && !lcd_e;
        wr_req = commit && !rw_q;
        ddram  = map_ddram(data_q[6:0]);

        unique case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    if (rs_q) begin
                        ram_we      = 1'b1;
                        wr_strobe_d = 1'b1;
                        cursor_d    = incr_q ? cursor_q + 1'b1 : cursor_q - 1'b1;
`ifdef LCD_RX_BUSY_EN
                        state_d     = ST_BUSY;
                        busy_cnt_d  = CNT_W'(BUSY_CYCLES - 1);
`endif
                    end else if (data_q == OP_CLEAR) begin
                        state_d   = ST_CLEAR;
                        clr_idx_d = '0;
                        cursor_d  = '0;
                        incr_d    = 1'b1;
                    end else begin
                        if (data_q[7:1] == OP_HOME[7:1]) begin
                            cursor_d = '0;
                        end else if (data_q[7:2] == OP_ENTRY[7:2]) begin
                            incr_d = data_q[1];
                        end else if (data_q[7] == OP_SET_DDRAM[7]) begin
                            if (ddram.valid) begin
                                cursor_d = ddram.idx;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
`ifdef LCD_RX_BUSY_EN
                        state_d = ST_BUSY;
                        if (data_q[7:1] == OP_HOME[7:1]) begin
                            busy_cnt_d = CNT_W'(BUSY_LONG_CYCLES - 1);
                        end else begin
                            busy_cnt_d = CNT_W'(BUSY_CYCLES - 1);
                        end
`endif
                    end
                end
            end

            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_idx_q;
                ram_wdata = SPACE;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
                if (wr_req) begin
                    err_d = 1'b1;
                end
            end

`ifdef LCD_RX_BUSY_EN
            ST_BUSY: begin
                if (busy_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    busy_cnt_d = busy_cnt_q - 1'b1;
                end
                if (wr_req) begin
                    err_d = 1'b1;
                end
            end
`endif

            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = '0;
            end
        endcase

        if (rst) begin
            ram_we = 1'b0;
        end
    end

    // State and bus-capture registers; reset restarts the clear sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= '0;
            cursor_q    <= '0;
            incr_q      <= 1'b1;
            err_q       <= 1'b0;
            wr_strobe_q <= 1'b0;
            e_q         <= 1'b0;
            rs_q        <= 1'b0;
            rw_q        <= 1'b0;
            data_q      <= '0;
`ifdef LCD_RX_BUSY_EN
            busy_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            cursor_q    <= cursor_d;
            incr_q      <= incr_d;
            err_q       <= err_d;
            wr_strobe_q <= wr_strobe_d;
            e_q         <= e_d;
            rs_q        <= rs_d;
            rw_q        <= rw_d;
            data_q      <= data_d;
`ifdef LCD_RX_BUSY_EN
            busy_cnt_q  <= busy_cnt_d;
`endif
        end
    end

    lcd_rx_ram u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (rd_char)
    );

    assign cursor    = cursor_q;
    assign wr_strobe = wr_strobe_q;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;

endmodule
